// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if
// Groups the request/result signals of the sequential binary-to-BCD converter.
//   start    : conversion request, sampled only while the converter is idle
//   bin      : unsigned binary value, captured on the edge that accepts start
//   busy     : conversion in progress (shift or done phase)
//   done     : one-cycle completion pulse
//   bcd      : packed BCD result, least-significant digit in bits [3:0]
//   overflow : result needed more than DIGITS digits
// master drives the request side, slave is the converter.
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;

  modport master (
    output start, bin,
    input  busy, done, bcd, overflow
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, overflow
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
// Sequential double-dabble binary-to-BCD converter. One bit is shifted in per
// clock, so a conversion takes WIDTH shift cycles plus one DONE cycle.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : bin2bcd_seq_if slave modport (start/bin in; busy/done/bcd/overflow out)
module bin2bcd_seq #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
) (
  input  logic           clk,
  input  logic           rst,
  bin2bcd_seq_if.slave   bus
);

  // Enough internal digits that 2^WIDTH-1 always fits.
  localparam int ID = (WIDTH * 3) / 10 + 1;
  localparam int CW = $clog2(WIDTH + 1);
  // Common width used to split the result into presented and overflow digits.
  localparam int WD = (ID > DIGITS) ? ID : DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t                state;
  state_t                state_next;

  logic [WIDTH-1:0]      shift_reg;
  logic [4*ID-1:0]       digits;
  logic [4*ID-1:0]       digits_adj;
  logic [4*ID+WIDTH-1:0] shifted;
  logic [4*WD-1:0]       digits_ext;
  logic [CW-1:0]         count;
  logic                  last_shift;
  logic                  accept;

  assign accept     = (state == IDLE) && bus.start;
  assign last_shift = (count == CW'(1));

  // Add-3 correction on every digit that would exceed 9 after doubling,
  // then the combined digit/binary register shifted left by one.
  always_comb begin
    digits_adj = '0;
    for (int i = 0; i < ID; i++) begin
      if (digits[4*i +: 4] >= 4'd5)
        digits_adj[4*i +: 4] = digits[4*i +: 4] + 4'd3;
      else
        digits_adj[4*i +: 4] = digits[4*i +: 4];
    end
    shifted    = {digits_adj, shift_reg} << 1;
    digits_ext = '0;
    digits_ext[4*ID-1:0] = shifted[WIDTH +: 4*ID];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start)
          state_next = SHIFT;
      end
      SHIFT: begin
        bus.busy = 1'b1;
        if (last_shift)
          state_next = DONE;
      end
      DONE: begin
        bus.busy   = 1'b1;
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The result registers are only written on the final shift, so they hold
  // the previous result for the whole of a conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg    <= '0;
      digits       <= '0;
      count        <= '0;
      bus.bcd      <= '0;
      bus.overflow <= 1'b0;
    end else if (accept) begin
      shift_reg <= bus.bin;
      digits    <= '0;
      count     <= CW'(WIDTH);
    end else if (state == SHIFT) begin
      {digits, shift_reg} <= shifted;
      count               <= count - CW'(1);
      if (last_shift) begin
        bus.bcd      <= digits_ext[4*DIGITS-1:0];
        bus.overflow <= |(digits_ext >> (4 * DIGITS));
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq
// Directed bench for bin2bcd_seq (WIDTH=32, DIGITS=8). Expected results come
// from a decimal model and are queued when a request is accepted, then popped
// when done is seen. Cycle numbering: the accepting edge is cycle 1.
module tb_bin2bcd_seq;

  localparam int WIDTH  = 32;
  localparam int DIGITS = 8;

  typedef struct packed {
    logic [4*DIGITS-1:0] bcd;
    logic                ovf;
  } exp_t;

  logic clk;
  logic rst;
  int   checkCount;
  int   passCount;
  exp_t sb[$];
  logic [4*DIGITS-1:0] lastBcd;

  bin2bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal reference: low DIGITS digits, overflow if anything remains.
  function automatic exp_t model(input logic [WIDTH-1:0] value);
    exp_t r;
    longint unsigned v;
    r = '0;
    v = longint'(value);
    for (int i = 0; i < DIGITS; i++) begin
      r.bcd[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    r.ovf = (v != 0);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Request a conversion; bin is scrambled right after acceptance.
  task automatic applyStimulus(input logic [WIDTH-1:0] value, input bit expectResult);
    bus.bin   = value;
    bus.start = 1'b1;
    if (expectResult)
      sb.push_back(model(value));
    tick();
    bus.start = 1'b0;
    bus.bin   = $urandom;
  endtask

  // Step until done, checking result hold along the way, then score it.
  task automatic collectResult(input string tag, input int startLat, input int expLat);
    int   lat;
    bit   seen;
    exp_t e;
    lat = startLat;
    while (bus.done !== 1'b1 && lat < 80) begin
      if (lat == 16)
        checkOutput({tag, "_hold"}, bus.bcd, lastBcd);
      tick();
      lat++;
    end
    seen = (bus.done === 1'b1);
    checkOutput({tag, "_latency"}, lat, expLat);
    checkOutput({tag, "_done_seen"}, seen, 1);
    if (seen) begin
      checkOutput({tag, "_sb_nonempty"}, sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput({tag, "_bcd"}, bus.bcd, e.bcd);
        checkOutput({tag, "_ovf"}, bus.overflow, e.ovf);
        checkOutput({tag, "_busy_in_done"}, bus.busy, 1);
        lastBcd = e.bcd;
      end
    end
  endtask

  task automatic noDoneWindow(input string tag, input int n);
    int pulses;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.done === 1'b1)
        pulses++;
    end
    checkOutput(tag, pulses, 0);
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    lastBcd    = '0;
    rst        = 1'b1;
    bus.start  = 1'b1;
    bus.bin    = 32'd123;

    // Reset state, with start held during reset.
    repeat (3) tick();
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_bcd", bus.bcd, 0);
    checkOutput("rst_ovf", bus.overflow, 0);
    bus.start = 1'b0;
    rst       = 1'b0;
    tick();
    checkOutput("idle_busy", bus.busy, 0);

    // Plain conversions.
    $display("[TB] single conversions");
    applyStimulus(32'd12345, 1'b1);
    checkOutput("c12345_busy", bus.busy, 1);
    collectResult("c12345", 1, 33);
    tick();
    checkOutput("c12345_done_width", bus.done, 0);
    checkOutput("c12345_busy_idle", bus.busy, 0);

    applyStimulus(32'd0, 1'b1);
    collectResult("c0", 1, 33);
    tick();
    applyStimulus(32'd99999999, 1'b1);
    collectResult("c99999999", 1, 33);
    tick();
    applyStimulus(32'd100000000, 1'b1);
    collectResult("c100000000", 1, 33);
    tick();
    applyStimulus(32'hFFFFFFFF, 1'b1);
    collectResult("cFFFFFFFF", 1, 33);
    tick();

    // Second start while busy is ignored.
    $display("[TB] start while busy");
    applyStimulus(32'd7, 1'b1);
    for (int c = 2; c < 10; c++) tick();
    bus.bin   = 32'd9;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checkOutput("restart_busy", bus.busy, 1);
    collectResult("restart", 10, 33);
    noDoneWindow("restart_single_done", 40);
    checkOutput("restart_sb_empty", sb.size(), 0);

    // Reset mid-conversion aborts it.
    $display("[TB] reset mid-shift");
    applyStimulus(32'd1234, 1'b0);
    for (int c = 2; c < 15; c++) tick();
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", bus.busy, 0);
    checkOutput("abort_done", bus.done, 0);
    checkOutput("abort_bcd", bus.bcd, 0);
    checkOutput("abort_ovf", bus.overflow, 0);
    tick();
    rst     = 1'b0;
    lastBcd = '0;
    noDoneWindow("abort_no_done", 40);
    applyStimulus(32'd42, 1'b1);
    collectResult("after_rst", 1, 33);
    tick();

    // start held high: back-to-back conversions every WIDTH+2 cycles.
    $display("[TB] back-to-back");
    bus.bin   = 32'd5;
    bus.start = 1'b1;
    for (int k = 0; k < 3; k++) sb.push_back(model(32'd5));
    tick();
    collectResult("b2b_0", 1, 33);
    tick();
    collectResult("b2b_1", 1, 34);
    tick();
    collectResult("b2b_2", 1, 34);
    bus.start = 1'b0;
    noDoneWindow("b2b_stop", 40);
    checkOutput("b2b_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
